yc_fmt_ctrl: RTL
================

// Module: yc_fmt_ctrl
// PURPOSE
//  Controller for the YCbCr 4:4:4 -> 4:2:2 YC converter stage. Tracks VS/HS/DE timing,
//  drives the per-pixel Cb/Cr select, and applies config only at frame boundaries.
//  Measures line length and line count, then reports lock and timing errors.
//  Sits beside the converter on the same clk; it taps the converter's VS/HS/DE inputs.
// PARAMETERS
//  PIX_W   13  width of active-pixel-per-line counter (saturating)
//  LINE_W  12  width of active-line-per-frame counter (saturating)
//  N_LOCK  2   consecutive consistent frames required to assert locked
// PORTS
//  clk           in   1       pixel clock
//  reset         in   1       asynchronous, active-high
//  VS_in         in   1       vertical sync, active-low (idle 1)
//  HS_in         in   1       horizontal sync, active-low (idle 1)
//  DE_in         in   1       data enable, active-high
//  cfg_cr_first  in   1       1: first active pixel of a line carries Cr
//  cfg_bypass    in   1       1: converter passes Cb on every pixel (no 4:2:2 interleave)
//  err_clr       in   1       single-cycle pulse, clears sticky errors
//  c_sel         out  1       0: Cb, 1: Cr; valid in the same cycle as DE_in
//  bypass_act    out  1       shadowed cfg_bypass in effect for the current frame
//  frame_start   out  1       one-cycle pulse, registered, cycle after VS 1->0 edge
//  line_len      out  PIX_W   active pixels counted on the last completed line
//  frame_lines   out  LINE_W  active lines counted in the last completed frame
//  locked        out  1       timing stable for N_LOCK frames
//  err_odd_len   out  1       sticky: a line had an odd active pixel count
//  err_mismatch  out  1       sticky: line length or line count changed while locked
// BEHAVIOUR
//  Reset: c_sel=0, bypass_act=0, frame_start=0, line_len=0, frame_lines=0, locked=0,
//   both errors 0, shadow cfg=0, FSM=S_WAIT_VS, phase=0, internal VS/DE history=1/0.
//  Edges: VS/DE history registers; VS fall = prev 1 & cur 0; DE fall = prev 1 & cur 0.
//  Shadowing: cfg_cr_first/cfg_bypass sampled into shadow regs on VS fall only.
//   bypass_act = shadow bypass. Mid-frame cfg changes take effect from the next frame.
//  Chroma phase: phase toggles every cycle DE_in=1 and is forced to 0 when DE_in=0.
//   c_sel = bypass_act ? 0 : (phase ^ shadow_cr_first). This is combinational from
//   registers and DE timing, so the first DE cycle of a line gives phase=0.
//  Counting: pix_cnt increments while DE_in=1 and saturates at all-ones. On DE fall:
//   line_len<=pix_cnt(final), line_cnt++ (saturating), pix_cnt<=0;
//   err_odd_len set if bit0=1 and bypass_act=0. On VS fall: frame_lines<=line_cnt,
//   line_cnt<=0, frame_start pulses the next cycle.
//  FSM (states in package):
//   S_WAIT_VS : ignore counting results; VS fall -> S_MEASURE.
//   S_MEASURE : first DE fall in the frame captures ref_len; later lines compare with it.
//     At VS fall: if all lines matched and line_cnt!=0, capture ref_lines and inc
//     good_cnt; else set good_cnt=0. good_cnt==N_LOCK -> S_LOCKED, locked=1.
//   S_LOCKED  : any line_len!=ref_len or frame line count!=ref_lines -> err_mismatch=1,
//     locked=0, good_cnt=0 -> S_MEASURE (new refs taken in the next frame).
//  Simultaneous events: DE fall and VS fall in the same cycle -> line closes first, then
//   the frame closes, so the closed line is included in frame_lines. err_clr together
//   with a new error -> the error stays set (set wins).
//  DE asserted during VS low is counted normally; no separate handling.
//  Reset mid-frame: everything returns to reset values; counting resumes only after the
//   next VS fall (partial frame discarded).
//  Saturated pix_cnt/line_cnt are treated as normal values for comparison.
// STRUCTURE
//  Package yc_ctrl_pkg: state enum {S_WAIT_VS,S_MEASURE,S_LOCKED}, default widths, and
//   C_SEL_CB=0/C_SEL_CR=1 constants shared with the converter stage.
//  Sub-module yc_timing_meas: edge detect, pix/line counters, line_len/frame_lines regs,
//   plus DE-fall and VS-fall strobes. Top level holds the FSM, shadow regs, phase and errors.
// TESTING
//  1 Reset, then 3 frames of 4 lines x 8 DE cycles, cfg_cr_first=0 -> c_sel 0,1,0,1..
//    per line; line_len=8, frame_lines=4; locked=1 after the 3rd VS fall (N_LOCK=2).
//  2 Set cfg_cr_first=1 mid-frame -> c_sel unchanged until next VS fall, then 1,0,1,0..
//  3 While locked, one line of 6 DE cycles -> err_mismatch=1, locked=0 at that DE fall;
//    relocks after 2 clean frames; err_clr pulse -> err_mismatch=0.
//  4 Line of 7 DE cycles, bypass_act=0 -> err_odd_len=1; the same with cfg_bypass=1
//    shadowed -> no error, c_sel held 0.
//  5 DE fall and VS fall in the same cycle -> frame_lines includes that line (4, not 3).
//  6 Assert reset mid-line -> all outputs are at reset values; no count until next VS fall.

Source files
------------

// File: rtl/yc_ctrl_pkg.sv
// Shared types and constants for the 4:4:4 -> 4:2:2 YC converter control path.
package yc_ctrl_pkg;

    localparam int PIX_W_DEF  = 13;
    localparam int LINE_W_DEF = 12;
    localparam int N_LOCK_DEF = 2;

    localparam logic C_SEL_CB = 1'b0;
    localparam logic C_SEL_CR = 1'b1;

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/yc_timing_meas.sv
// VS/DE edge detection plus saturating pixel/line counters and the measured
// line length / frame line count registers.
module yc_timing_meas
    import yc_ctrl_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic              count_en,
    output logic              vs_fall,
    output logic              de_fall,
    output logic [PIX_W-1:0]  pix_cnt,
    output logic [LINE_W-1:0] line_total,
    output logic [PIX_W-1:0]  line_len,
    output logic [LINE_W-1:0] frame_lines,
    output logic              frame_start
);

    logic              vs_prev_q, vs_prev_d;
    logic              de_prev_q, de_prev_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [PIX_W-1:0]  line_len_q, line_len_d;
    logic [LINE_W-1:0] frame_lines_q, frame_lines_d;
    logic              frame_start_q, frame_start_d;

    always_comb begin
        vs_fall = vs_prev_q & ~vs_in;
        de_fall = de_prev_q & ~de_in;
        // A line closing in the same cycle as VS fall belongs to the closing frame.
        line_total = (de_fall && (line_cnt_q != '1)) ? line_cnt_q + LINE_W'(1) : line_cnt_q;

        vs_prev_d     = vs_in;
        de_prev_d     = de_in;
        frame_start_d = vs_fall;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;

        if (count_en) begin
            if (de_in && (pix_cnt_q != '1)) begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
            if (de_fall) begin
                line_len_d = pix_cnt_q;
                pix_cnt_d  = '0;
                line_cnt_d = line_total;
            end
            if (vs_fall) begin
                frame_lines_d = line_total;
                line_cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev_q     <= 1'b1;
            de_prev_q     <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            frame_start_q <= 1'b0;
        end else begin
            vs_prev_q     <= vs_prev_d;
            de_prev_q     <= de_prev_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_cnt     = pix_cnt_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_start = frame_start_q;

endmodule

// File: rtl/yc_fmt_ctrl.sv
// Control for the YC 4:2:2 converter: frame-aligned config shadowing, Cb/Cr
// select, timing lock FSM and sticky timing errors.
module yc_fmt_ctrl
    import yc_ctrl_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int N_LOCK = N_LOCK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              VS_in,
    input  logic              HS_in,
    input  logic              DE_in,
    input  logic              cfg_cr_first,
    input  logic              cfg_bypass,
    input  logic              err_clr,
    output logic              c_sel,
    output logic              bypass_act,
    output logic              frame_start,
    output logic [PIX_W-1:0]  line_len,
    output logic [LINE_W-1:0] frame_lines,
    output logic              locked,
    output logic              err_odd_len,
    output logic              err_mismatch
);

    localparam int GOOD_W = $clog2(N_LOCK + 1);

    ctrl_state_e       state_q, state_d;
    logic              cr_first_q, cr_first_d;
    logic              bypass_q, bypass_d;
    logic              phase_q, phase_d;
    logic              err_odd_q, err_odd_d;
    logic              err_mm_q, err_mm_d;
    logic              first_line_q, first_line_d;
    logic              match_q, match_d;
    logic [PIX_W-1:0]  ref_len_q, ref_len_d;
    logic [LINE_W-1:0] ref_lines_q, ref_lines_d;
    logic [GOOD_W-1:0] good_q, good_d;

    logic              vs_fall, de_fall, count_en;
    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_total;
    logic              frame_match, err_odd_set, err_mm_set;
    logic [GOOD_W-1:0] good_inc;

    // Line sync carries no information this controller needs.
    logic hs_unused;
    assign hs_unused = HS_in;

    yc_timing_meas #(
        .PIX_W  (PIX_W),
        .LINE_W (LINE_W)
    ) u_meas (
        .clk         (clk),
        .reset       (reset),
        .vs_in       (VS_in),
        .de_in       (DE_in),
        .count_en    (count_en),
        .vs_fall     (vs_fall),
        .de_fall     (de_fall),
        .pix_cnt     (pix_cnt),
        .line_total  (line_total),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .frame_start (frame_start)
    );

    assign count_en = (state_q != S_WAIT_VS);

    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        ref_len_d    = ref_len_q;
        ref_lines_d  = ref_lines_q;
        first_line_d = first_line_q;
        match_d      = match_q;
        err_mm_set   = 1'b0;
        good_inc     = good_q + GOOD_W'(1);
        frame_match  = match_q && !(de_fall && !first_line_q && (pix_cnt != ref_len_q));

        case (state_q)
            S_WAIT_VS: begin
                if (vs_fall) begin
                    state_d      = S_MEASURE;
                    first_line_d = 1'b1;
                    match_d      = 1'b1;
                    good_d       = '0;
                end
            end
            S_MEASURE: begin
                if (de_fall) begin
                    if (first_line_q) begin
                        ref_len_d    = pix_cnt;
                        first_line_d = 1'b0;
                    end else if (pix_cnt != ref_len_q) begin
                        match_d = 1'b0;
                    end
                end
                if (vs_fall) begin
                    first_line_d = 1'b1;
                    match_d      = 1'b1;
                    if (frame_match && (line_total != '0)) begin
                        ref_lines_d = line_total;
                        good_d      = good_inc;
                        if (good_inc == GOOD_W'(N_LOCK)) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            S_LOCKED: begin
                if ((de_fall && (pix_cnt != ref_len_q)) ||
                    (vs_fall && (line_total != ref_lines_q))) begin
                    err_mm_set   = 1'b1;
                    good_d       = '0;
                    state_d      = S_MEASURE;
                    first_line_d = 1'b1;
                    // A mid-frame loss taints the rest of this frame; refs restart next frame.
                    match_d      = vs_fall;
                end else if (vs_fall) begin
                    first_line_d = 1'b1;
                    match_d      = 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT_VS;
            end
        endcase
    end

    always_comb begin
        cr_first_d  = vs_fall ? cfg_cr_first : cr_first_q;
        bypass_d    = vs_fall ? cfg_bypass : bypass_q;
        phase_d     = DE_in ? ~phase_q : 1'b0;
        err_odd_set = de_fall && count_en && pix_cnt[0] && !bypass_q;
        // Set wins over a coincident clear.
        err_odd_d   = (err_odd_q & ~err_clr) | err_odd_set;
        err_mm_d    = (err_mm_q & ~err_clr) | err_mm_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_WAIT_VS;
            cr_first_q   <= 1'b0;
            bypass_q     <= 1'b0;
            phase_q      <= 1'b0;
            err_odd_q    <= 1'b0;
            err_mm_q     <= 1'b0;
            first_line_q <= 1'b1;
            match_q      <= 1'b1;
            ref_len_q    <= '0;
            ref_lines_q  <= '0;
            good_q       <= '0;
        end else begin
            state_q      <= state_d;
            cr_first_q   <= cr_first_d;
            bypass_q     <= bypass_d;
            phase_q      <= phase_d;
            err_odd_q    <= err_odd_d;
            err_mm_q     <= err_mm_d;
            first_line_q <= first_line_d;
            match_q      <= match_d;
            ref_len_q    <= ref_len_d;
            ref_lines_q  <= ref_lines_d;
            good_q       <= good_d;
        end
    end

    assign c_sel        = bypass_q ? C_SEL_CB : (phase_q ^ cr_first_q);
    assign bypass_act   = bypass_q;
    assign locked       = (state_q == S_LOCKED);
    assign err_odd_len  = err_odd_q;
    assign err_mismatch = err_mm_q;

endmodule
